trap_responder: RTL and testbench

- Receiving end of the trap-request interface produced by the M-stage trap logic.
- Consumes TrapM/InterruptM/DelegateM/CauseM and mret/sret, and updates the trap-state CSRs:
  - machine and supervisor EPC, CAUSE, TVAL;
  - the MIE/MPIE/MPP and SIE/SPIE/SPP status stack;
  - the current privilege mode.
- Computes the redirect PC (trap vector or return target) for the fetch unit.
- Sits beside the CSR file in the privileged unit.
- Its privilege and status outputs feed back into the trap logic's interrupt enables.

---
 rtl/trap_responder_if.sv | 31 +++
 rtl/trap_responder.sv | 184 ++++++++++++++++++
 tb/tb_trap_responder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/trap_responder_if.sv
// Trap-request bus from the M-stage trap logic to the trap responder, with the
// redirect returned to fetch.
interface trap_responder_if #(
  parameter int unsigned XLEN = 64
);
  logic            TrapM;
  logic            InterruptM;
  logic            DelegateM;
  logic [3:0]      CauseM;
  logic            mretM;
  logic            sretM;
  logic [XLEN-1:0] PCM;
  logic [XLEN-1:0] TvalM;
  logic            CSRWriteM;
  logic [11:0]     CSRAdrM;
  logic [XLEN-1:0] CSRWriteValM;
  logic            RedirectM;
  logic [XLEN-1:0] RedirectPCM;

  modport master (
    output TrapM, InterruptM, DelegateM, CauseM, mretM, sretM, PCM, TvalM,
           CSRWriteM, CSRAdrM, CSRWriteValM,
    input  RedirectM, RedirectPCM
  );

  modport slave (
    input  TrapM, InterruptM, DelegateM, CauseM, mretM, sretM, PCM, TvalM,
           CSRWriteM, CSRAdrM, CSRWriteValM,
    output RedirectM, RedirectPCM
  );
endinterface

// File: rtl/trap_responder.sv
// Trap responder: updates trap CSRs, the status stack and privilege mode, and
// computes the fetch redirect. Optional TRAP_NEST_CNT_EN adds a TrapDepth counter.
module trap_responder #(
  parameter int unsigned XLEN        = 64,
  parameter bit          S_SUPPORTED = 1'b1,
  parameter bit          U_SUPPORTED = 1'b1,
  parameter bit          C_SUPPORTED = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  trap_responder_if.slave trap_if,
  output logic [1:0]      PrivilegeModeW,
  output logic            STATUS_MIE,
  output logic            STATUS_SIE,
  output logic            STATUS_MPIE,
  output logic            STATUS_SPIE,
  output logic            STATUS_SPP,
  output logic [1:0]      STATUS_MPP,
  output logic [XLEN-1:0] MEPC_REGW,
  output logic [XLEN-1:0] SEPC_REGW,
  output logic [XLEN-1:0] MCAUSE_REGW,
  output logic [XLEN-1:0] SCAUSE_REGW,
  output logic [XLEN-1:0] MTVAL_REGW,
  output logic [XLEN-1:0] STVAL_REGW,
  output logic [XLEN-1:0] MTVEC_REGW,
  output logic [XLEN-1:0] STVEC_REGW
`ifdef TRAP_NEST_CNT_EN
  ,
  output logic [3:0]      TrapDepth
`endif
);

  localparam logic [1:0] PrivM = 2'b11;
  localparam logic [1:0] PrivS = 2'b01;
  localparam logic [1:0] MppRet = U_SUPPORTED ? 2'b00 : 2'b11;
  localparam logic [XLEN-1:0] EpcMask =
    C_SUPPORTED ? {{(XLEN-1){1'b1}}, 1'b0} : {{(XLEN-2){1'b1}}, 2'b00};

  logic [1:0]      priv_q, priv_d, mpp_q, mpp_d;
  logic            mie_q, mie_d, sie_q, sie_d, mpie_q, mpie_d, spie_q, spie_d, spp_q, spp_d;
  logic [XLEN-1:0] mepc_q, mepc_d, sepc_q, sepc_d, mcause_q, mcause_d, scause_q, scause_d;
  logic [XLEN-1:0] mtval_q, mtval_d, stval_q, stval_d, mtvec_q, mtvec_d, stvec_q, stvec_d;

  logic            s_trap, m_trap, m_ret, s_ret, sret_ok, csr_we;
  logic [XLEN-1:0] cause_val, trap_vec, trap_base, cause_off, wval;

  // Mode encodings 2 and 3 are reserved; they collapse to direct mode.
  function automatic logic [XLEN-1:0] tvec_warl(input logic [XLEN-1:0] v);
    return {v[XLEN-1:2], v[1] ? 2'b00 : v[1:0]};
  endfunction

  assign sret_ok = trap_if.sretM & S_SUPPORTED;
  assign s_trap  = trap_if.TrapM & trap_if.DelegateM & S_SUPPORTED;
  assign m_trap  = trap_if.TrapM & ~s_trap;
  assign m_ret   = ~trap_if.TrapM & trap_if.mretM;
  assign s_ret   = ~trap_if.TrapM & ~trap_if.mretM & sret_ok;
  assign csr_we  = trap_if.CSRWriteM & ~trap_if.TrapM & ~trap_if.mretM & ~sret_ok;
  assign wval    = trap_if.CSRWriteValM;

  assign cause_val = {trap_if.InterruptM, {(XLEN-5){1'b0}}, trap_if.CauseM};
  assign trap_vec  = s_trap ? stvec_q : mtvec_q;
  assign trap_base = {trap_vec[XLEN-1:2], 2'b00};
  assign cause_off = {{(XLEN-6){1'b0}}, trap_if.CauseM, 2'b00};

  assign trap_if.RedirectM = trap_if.TrapM | trap_if.mretM | sret_ok;

  always_comb begin
    trap_if.RedirectPCM = '0;
    if (trap_if.TrapM) begin
      trap_if.RedirectPCM = (trap_if.InterruptM && trap_vec[1:0] == 2'b01) ?
                            trap_base + cause_off : trap_base;
    end else if (trap_if.mretM) begin
      trap_if.RedirectPCM = mepc_q;
    end else if (sret_ok) begin
      trap_if.RedirectPCM = sepc_q;
    end
  end

  always_comb begin
    priv_d   = priv_q;   mpp_d    = mpp_q;
    mie_d    = mie_q;    sie_d    = sie_q;
    mpie_d   = mpie_q;   spie_d   = spie_q;   spp_d   = spp_q;
    mepc_d   = mepc_q;   sepc_d   = sepc_q;
    mcause_d = mcause_q; scause_d = scause_q;
    mtval_d  = mtval_q;  stval_d  = stval_q;
    mtvec_d  = mtvec_q;  stvec_d  = stvec_q;
    if (m_trap) begin
      mepc_d   = trap_if.PCM & EpcMask;
      mcause_d = cause_val;
      mtval_d  = trap_if.TvalM;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = priv_q;
      priv_d   = PrivM;
    end else if (s_trap) begin
      sepc_d   = trap_if.PCM & EpcMask;
      scause_d = cause_val;
      stval_d  = trap_if.TvalM;
      spie_d   = sie_q;
      sie_d    = 1'b0;
      spp_d    = priv_q[0];
      priv_d   = PrivS;
    end else if (m_ret) begin
      priv_d   = mpp_q;
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
      mpp_d    = MppRet;
    end else if (s_ret) begin
      priv_d   = {1'b0, spp_q};
      sie_d    = spie_q;
      spie_d   = 1'b1;
      spp_d    = 1'b0;
    end else if (csr_we) begin
      case (trap_if.CSRAdrM)
        12'h305: mtvec_d  = tvec_warl(wval);
        12'h341: mepc_d   = wval & EpcMask;
        12'h342: mcause_d = wval;
        12'h343: mtval_d  = wval;
        12'h105: if (S_SUPPORTED) stvec_d  = tvec_warl(wval);
        12'h141: if (S_SUPPORTED) sepc_d   = wval & EpcMask;
        12'h142: if (S_SUPPORTED) scause_d = wval;
        12'h143: if (S_SUPPORTED) stval_d  = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      priv_q   <= PrivM;    mpp_q    <= MppRet;
      mie_q    <= 1'b0;     sie_q    <= 1'b0;
      mpie_q   <= 1'b0;     spie_q   <= 1'b0;   spp_q   <= 1'b0;
      mepc_q   <= '0;       sepc_q   <= '0;
      mcause_q <= '0;       scause_q <= '0;
      mtval_q  <= '0;       stval_q  <= '0;
      mtvec_q  <= '0;       stvec_q  <= '0;
    end else begin
      priv_q   <= priv_d;   mpp_q    <= mpp_d;
      mie_q    <= mie_d;    sie_q    <= sie_d;
      mpie_q   <= mpie_d;   spie_q   <= spie_d; spp_q   <= spp_d;
      mepc_q   <= mepc_d;   sepc_q   <= sepc_d;
      mcause_q <= mcause_d; scause_q <= scause_d;
      mtval_q  <= mtval_d;  stval_q  <= stval_d;
      mtvec_q  <= mtvec_d;  stvec_q  <= stvec_d;
    end
  end

`ifdef TRAP_NEST_CNT_EN
  logic [3:0] depth_q, depth_d;

  always_comb begin
    depth_d = depth_q;
    if (trap_if.TrapM) begin
      if (depth_q != 4'hf) depth_d = depth_q + 4'd1;
    end else if (m_ret || s_ret) begin
      if (depth_q != 4'h0) depth_d = depth_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

  assign TrapDepth = depth_q;
`endif

  assign PrivilegeModeW = priv_q;
  assign STATUS_MIE     = mie_q;
  assign STATUS_SIE     = sie_q;
  assign STATUS_MPIE    = mpie_q;
  assign STATUS_SPIE    = spie_q;
  assign STATUS_SPP     = spp_q;
  assign STATUS_MPP     = mpp_q;
  assign MEPC_REGW      = mepc_q;
  assign SEPC_REGW      = sepc_q;
  assign MCAUSE_REGW    = mcause_q;
  assign SCAUSE_REGW    = scause_q;
  assign MTVAL_REGW     = mtval_q;
  assign STVAL_REGW     = stval_q;
  assign MTVEC_REGW     = mtvec_q;
  assign STVEC_REGW     = stvec_q;

endmodule

// File: tb/tb_trap_responder.sv
// Randomized bench for trap_responder against a CSR-map / mstatus-word model.
// Covers TrapDepth when TRAP_NEST_CNT_EN is defined.
module tb_trap_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  trap_responder_if #(.XLEN(64)) tif ();

  logic [1:0]  priv_w, mpp_w;
  logic        mie_w, sie_w, mpie_w, spie_w, spp_w;
  logic [63:0] mepc_w, sepc_w, mcause_w, scause_w, mtval_w, stval_w, mtvec_w, stvec_w;
`ifdef TRAP_NEST_CNT_EN
  logic [3:0]  depth_w;
`endif

  trap_responder #(.XLEN(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .trap_if        (tif),
    .PrivilegeModeW (priv_w),
    .STATUS_MIE     (mie_w),
    .STATUS_SIE     (sie_w),
    .STATUS_MPIE    (mpie_w),
    .STATUS_SPIE    (spie_w),
    .STATUS_SPP     (spp_w),
    .STATUS_MPP     (mpp_w),
    .MEPC_REGW      (mepc_w),
    .SEPC_REGW      (sepc_w),
    .MCAUSE_REGW    (mcause_w),
    .SCAUSE_REGW    (scause_w),
    .MTVAL_REGW     (mtval_w),
    .STVAL_REGW     (stval_w),
    .MTVEC_REGW     (mtvec_w),
    .STVEC_REGW     (stvec_w)
`ifdef TRAP_NEST_CNT_EN
    ,
    .TrapDepth      (depth_w)
`endif
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: CSRs by address, status as an architectural mstatus word.
  // mstatus bits: SIE 1, MIE 3, SPIE 5, MPIE 7, SPP 8, MPP 12:11.
  logic [63:0] csr [int];
  logic [63:0] ms;
  logic [1:0]  m_priv;
  int          m_depth;
  logic [63:0] last_pc;
  int          addrs [9] = '{'h305, 'h341, 'h342, 'h343, 'h105, 'h141, 'h142, 'h143, 'h300};

  task automatic model_reset();
    for (int k = 0; k < 8; k++) csr[addrs[k]] = 64'h0;
    ms      = 64'h0;
    m_priv  = 2'b11;
    m_depth = 0;
  endtask

  task automatic check_state();
    check("priv",   64'(priv_w),  64'(m_priv));
    check("mie",    64'(mie_w),   64'(ms[3]));
    check("sie",    64'(sie_w),   64'(ms[1]));
    check("mpie",   64'(mpie_w),  64'(ms[7]));
    check("spie",   64'(spie_w),  64'(ms[5]));
    check("spp",    64'(spp_w),   64'(ms[8]));
    check("mpp",    64'(mpp_w),   64'(ms[12:11]));
    check("mtvec",  mtvec_w,  csr['h305]);
    check("mepc",   mepc_w,   csr['h341]);
    check("mcause", mcause_w, csr['h342]);
    check("mtval",  mtval_w,  csr['h343]);
    check("stvec",  stvec_w,  csr['h105]);
    check("sepc",   sepc_w,   csr['h141]);
    check("scause", scause_w, csr['h142]);
    check("stval",  stval_w,  csr['h143]);
`ifdef TRAP_NEST_CNT_EN
    check("depth",  64'(depth_w), 64'(m_depth));
`endif
  endtask

  task automatic apply(input logic t, input logic i, input logic d, input logic [3:0] c,
                       input logic mr, input logic sr, input logic [63:0] pc,
                       input logic [63:0] tv, input logic we, input logic [11:0] adr,
                       input logic [63:0] wd);
    logic [63:0] vec, base, exp_pc, v;
    tif.TrapM = t;  tif.InterruptM = i; tif.DelegateM = d; tif.CauseM = c;
    tif.mretM = mr; tif.sretM = sr;     tif.PCM = pc;      tif.TvalM = tv;
    tif.CSRWriteM = we; tif.CSRAdrM = adr; tif.CSRWriteValM = wd;
    #1;
    exp_pc = 64'h0;
    if (t) begin
      vec    = d ? csr['h105] : csr['h305];
      base   = vec & ~64'h3;
      exp_pc = (i && vec[1:0] == 2'b01) ? base + 64'(c) * 4 : base;
    end else if (mr) exp_pc = csr['h341];
    else if (sr)     exp_pc = csr['h141];
    check("redirect",    64'(tif.RedirectM), 64'(t | mr | sr));
    check("redirect_pc", tif.RedirectPCM, exp_pc);
    last_pc = tif.RedirectPCM;
    if (t) begin
      if (d) begin
        csr['h141] = pc & ~64'h1; csr['h142] = {i, 59'b0, c}; csr['h143] = tv;
        ms[5] = ms[1]; ms[1] = 1'b0; ms[8] = m_priv[0]; m_priv = 2'b01;
      end else begin
        csr['h341] = pc & ~64'h1; csr['h342] = {i, 59'b0, c}; csr['h343] = tv;
        ms[7] = ms[3]; ms[3] = 1'b0; ms[12:11] = m_priv; m_priv = 2'b11;
      end
      if (m_depth < 15) m_depth++;
    end else if (mr) begin
      m_priv = ms[12:11]; ms[3] = ms[7]; ms[7] = 1'b1; ms[12:11] = 2'b00;
      if (m_depth > 0) m_depth--;
    end else if (sr) begin
      m_priv = {1'b0, ms[8]}; ms[1] = ms[5]; ms[5] = 1'b1; ms[8] = 1'b0;
      if (m_depth > 0) m_depth--;
    end else if (we && csr.exists(int'(adr))) begin
      v = wd;
      if (adr == 12'h305 || adr == 12'h105) begin
        if (v[1]) v[1:0] = 2'b00;
      end else if (adr == 12'h341 || adr == 12'h141) v[0] = 1'b0;
      csr[int'(adr)] = v;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic trap(input logic i, input logic d, input logic [3:0] c,
                      input logic [63:0] pc, input logic [63:0] tv);
    apply(1'b1, i, d, c, 1'b0, 1'b0, pc, tv, 1'b0, 12'h0, 64'h0);
  endtask

  task automatic ret(input logic mr, input logic sr);
    apply(1'b0, 1'b0, 1'b0, 4'h0, mr, sr, 64'h0, 64'h0, 1'b0, 12'h0, 64'h0);
  endtask

  task automatic csr_wr(input logic [11:0] adr, input logic [63:0] wd);
    apply(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, adr, wd);
  endtask

  initial begin
    reset = 1'b1;
    tif.TrapM = 1'b0; tif.InterruptM = 1'b0; tif.DelegateM = 1'b0; tif.CauseM = 4'h0;
    tif.mretM = 1'b0; tif.sretM = 1'b0; tif.PCM = 64'h0; tif.TvalM = 64'h0;
    tif.CSRWriteM = 1'b0; tif.CSRAdrM = 12'h0; tif.CSRWriteValM = 64'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("rst_priv",     64'(priv_w), 64'd3);
    check("rst_mpp",      64'(mpp_w),  64'd0);
    check("rst_redirect", 64'(tif.RedirectM), 64'd0);
    check_state();

    // Reach U-mode with MIE=1, then take an exception.
    csr_wr(12'h305, 64'h4000);
    ret(1'b1, 1'b0);
    ret(1'b1, 1'b0);
    check("u_mie", 64'(mie_w), 64'd1);
    trap(1'b0, 1'b0, 4'd8, 64'h1003, 64'h0);
    check("exc_redir_pc", last_pc, 64'h4000);
    check("exc_mepc",     mepc_w, 64'h1002);
    check("exc_mcause",   mcause_w, 64'd8);
    check("exc_mpie",     64'(mpie_w), 64'd1);
    check("exc_priv",     64'(priv_w), 64'd3);

    // Vectored interrupt vs exception.
    csr_wr(12'h305, 64'h8000_0001);
    trap(1'b1, 1'b0, 4'd7, 64'h2000, 64'h0);
    check("vec_irq_pc", last_pc, 64'h8000_001C);
    trap(1'b0, 1'b0, 4'd7, 64'h2004, 64'h0);
    check("vec_exc_pc", last_pc, 64'h8000_0000);

    // Walk to S-mode with SIE=1, then a delegated trap and sret.
    csr_wr(12'h105, 64'h9000);
    trap(1'b0, 1'b1, 4'd2, 64'h3000, 64'h0);
    ret(1'b0, 1'b1);
    ret(1'b0, 1'b1);
    trap(1'b0, 1'b0, 4'd3, 64'h3100, 64'h0);
    trap(1'b0, 1'b1, 4'd2, 64'h3200, 64'h0);
    ret(1'b0, 1'b1);
    check("s_sie", 64'(sie_w), 64'd1);
    trap(1'b0, 1'b1, 4'd13, 64'h5554, 64'hDEAD);
    check("s_scause", scause_w, 64'd13);
    check("s_stval",  stval_w,  64'hDEAD);
    check("s_spp",    64'(spp_w), 64'd1);
    check("s_priv",   64'(priv_w), 64'd1);
    ret(1'b0, 1'b1);
    check("sret_pc",  last_pc, 64'h5554);
    check("sret_sie", 64'(sie_w), 64'd1);

    // From S: M trap sets MPP=1, then mret+sret together.
    trap(1'b0, 1'b0, 4'd2, 64'h6000, 64'h0);
    ret(1'b1, 1'b1);
    check("mret_sret_priv", 64'(priv_w), 64'd1);

    // Trap beats CSR write; plain writes with WARL.
    apply(1'b1, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 64'h7770, 64'h0, 1'b1, 12'h341, 64'h1234);
    check("trap_vs_wr", mepc_w, 64'h7770);
    csr_wr(12'h342, 64'h5);
    check("wr_mcause", mcause_w, 64'h5);
    csr_wr(12'h305, 64'hABC3);
    check("wr_mtvec", mtvec_w, 64'hABC0);

`ifdef TRAP_NEST_CNT_EN
    repeat (16) trap(1'b0, 1'b0, 4'd1, 64'h100, 64'h0);
    check("depth_sat_hi", 64'(depth_w), 64'd15);
    repeat (16) ret(1'b1, 1'b0);
    check("depth_sat_lo", 64'(depth_w), 64'd0);
`endif

    for (int n = 0; n < 400; n++) begin
      apply(1'($urandom_range(0, 99) < 20), 1'($urandom), 1'($urandom), 4'($urandom),
            1'($urandom_range(0, 99) < 12), 1'($urandom_range(0, 99) < 12),
            {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 99) < 50), 12'(addrs[$urandom_range(0, 8)]),
            {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
